// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the decode/execute pipeline slice.
// Word/register types, ALU opcodes and destination-select encoding.
package cpu_types_pkg;

    localparam int WORD_BITS = 32;
    localparam int REG_BITS  = 5;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [REG_BITS-1:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_NOR  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } aluop_t;

    typedef enum logic [1:0] {
        RD_RT   = 2'd0,
        RD_RD   = 2'd1,
        RD_LINK = 2'd2
    } regdst_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check: a load in EX whose destination is read by the
// instruction in ID. Ports: EX load info in, ID source info in, hazard out.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_memrd,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs && (ex_rd == id_rs);
    assign rt_hit = id_uses_rt && (ex_rd == id_rt);
    assign hazard = ex_valid && ex_memrd && (ex_rd != '0) && id_valid
                    && (rs_hit || rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use stall, WB bypass, hold and flush.
// Ports: CLK/nRST, en/flush control, id_* decode bundle, wb_* bypass, ex_* out.
module id_ex_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int REG_W    = 5,
    parameter int CNT_W    = 32,
    parameter int LINK_REG = 31
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [REG_W-1:0]  id_rs_i,
    input  logic [REG_W-1:0]  id_rt_i,
    input  logic [REG_W-1:0]  id_rd_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic [1:0]        id_regdst_i,
    input  logic              id_regwr_i,
    input  logic              id_memwr_i,
    input  logic              id_memrd_i,
    input  logic              id_alusrc_i,
    input  aluop_t            id_aluop_i,
    input  logic [WORD_W-1:0] id_imm_i,
    input  logic [WORD_W-1:0] id_rdat1_i,
    input  logic [WORD_W-1:0] id_rdat2_i,
    input  logic [WORD_W-1:0] id_npc_i,
    input  logic              wb_regwr_i,
    input  logic [REG_W-1:0]  wb_rd_i,
    input  logic [WORD_W-1:0] wb_wdat_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [REG_W-1:0]  ex_rs_o,
    output logic [REG_W-1:0]  ex_rt_o,
    output logic [REG_W-1:0]  ex_rd_o,
    output logic              ex_regwr_o,
    output logic              ex_memwr_o,
    output logic              ex_memrd_o,
    output logic              ex_alusrc_o,
    output aluop_t            ex_aluop_o,
    output logic [WORD_W-1:0] ex_imm_o,
    output logic [WORD_W-1:0] ex_rdat1_o,
    output logic [WORD_W-1:0] ex_rdat2_o,
    output logic [WORD_W-1:0] ex_npc_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              hazard;
    logic              flush_pend;
    logic              kill;
    logic              count_bubble;
    logic [REG_W-1:0]  dest;
    logic              regwr_res;
    logic [WORD_W-1:0] byp1;
    logic [WORD_W-1:0] byp2;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_valid   (ex_valid_o),
        .ex_memrd   (ex_memrd_o),
        .ex_rd      (ex_rd_o),
        .id_valid   (id_valid_i),
        .id_uses_rs (id_uses_rs_i),
        .id_uses_rt (id_uses_rt_i),
        .id_rs      (id_rs_i),
        .id_rt      (id_rt_i),
        .hazard     (hazard)
    );

    assign stall_o = hazard;

    always_comb begin
        dest = '0;
        case (id_regdst_i)
            RD_RT:   dest = id_rt_i;
            RD_RD:   dest = id_rd_i;
            RD_LINK: dest = REG_W'(LINK_REG);
            default: dest = '0;
        endcase
        // A write to $0 is meaningless; dropping it keeps forwarding quiet.
        regwr_res = id_regwr_i && (dest != '0);
        byp1 = id_rdat1_i;
        byp2 = id_rdat2_i;
        if (wb_regwr_i && (wb_rd_i == id_rs_i) && (id_rs_i != '0))
            byp1 = wb_wdat_i;
        if (wb_regwr_i && (wb_rd_i == id_rt_i) && (id_rt_i != '0))
            byp2 = wb_wdat_i;
        // Flush outranks the hazard, so only hazard-only bubbles count.
        kill = flush_i || flush_pend || hazard;
        count_bubble = hazard && !flush_i && !flush_pend
                       && (bubble_cnt_o != '1);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            flush_pend   <= 1'b0;
            bubble_cnt_o <= '0;
            ex_valid_o   <= 1'b0;
            ex_rs_o      <= '0;
            ex_rt_o      <= '0;
            ex_rd_o      <= '0;
            ex_regwr_o   <= 1'b0;
            ex_memwr_o   <= 1'b0;
            ex_memrd_o   <= 1'b0;
            ex_alusrc_o  <= 1'b0;
            ex_aluop_o   <= ALU_SLL;
            ex_imm_o     <= '0;
            ex_rdat1_o   <= '0;
            ex_rdat2_o   <= '0;
            ex_npc_o     <= '0;
        end else if (!en_i) begin
            if (flush_i)
                flush_pend <= 1'b1;
        end else begin
            flush_pend <= 1'b0;
            if (count_bubble)
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
            if (kill) begin
                ex_valid_o  <= 1'b0;
                ex_rs_o     <= '0;
                ex_rt_o     <= '0;
                ex_rd_o     <= '0;
                ex_regwr_o  <= 1'b0;
                ex_memwr_o  <= 1'b0;
                ex_memrd_o  <= 1'b0;
                ex_alusrc_o <= 1'b0;
                ex_aluop_o  <= ALU_SLL;
                ex_imm_o    <= '0;
                ex_rdat1_o  <= '0;
                ex_rdat2_o  <= '0;
                ex_npc_o    <= '0;
            end else begin
                ex_valid_o  <= id_valid_i;
                ex_rs_o     <= id_rs_i;
                ex_rt_o     <= id_rt_i;
                ex_rd_o     <= dest;
                ex_regwr_o  <= regwr_res;
                ex_memwr_o  <= id_memwr_i;
                ex_memrd_o  <= id_memrd_i;
                ex_alusrc_o <= id_alusrc_i;
                ex_aluop_o  <= id_aluop_i;
                ex_imm_o    <= id_imm_i;
                ex_rdat1_o  <= byp1;
                ex_rdat2_o  <= byp2;
                ex_npc_o    <= id_npc_i;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic against a behavioural model of the stage.
module tb_id_ex_stage;
    import cpu_types_pkg::*;

    localparam int CNT_W = 3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        en, flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        uses_rs, uses_rt;
    logic [1:0]  regdst;
    logic        regwr, memwr, memrd, alusrc;
    aluop_t      aluop;
    logic [31:0] imm, rdat1, rdat2, npc;
    logic        wb_regwr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdat;

    logic        stall, ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_regwr, ex_memwr, ex_memrd, ex_alusrc;
    aluop_t      ex_aluop;
    logic [31:0] ex_imm, ex_rdat1, ex_rdat2, ex_npc;
    logic [CNT_W-1:0] bcnt;

    int tests = 0;
    int fails = 0;

    // behavioural model of the EX-side state
    logic        m_valid;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic        m_regwr, m_memwr, m_memrd, m_alusrc;
    aluop_t      m_aluop;
    logic [31:0] m_imm, m_rdat1, m_rdat2, m_npc;
    logic [CNT_W-1:0] m_cnt;
    logic        m_pend;

    always #5 CLK = ~CLK;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .en_i(en), .flush_i(flush),
        .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .id_rd_i(id_rd), .id_uses_rs_i(uses_rs), .id_uses_rt_i(uses_rt),
        .id_regdst_i(regdst), .id_regwr_i(regwr), .id_memwr_i(memwr),
        .id_memrd_i(memrd), .id_alusrc_i(alusrc), .id_aluop_i(aluop),
        .id_imm_i(imm), .id_rdat1_i(rdat1), .id_rdat2_i(rdat2),
        .id_npc_i(npc), .wb_regwr_i(wb_regwr), .wb_rd_i(wb_rd),
        .wb_wdat_i(wb_wdat), .stall_o(stall), .ex_valid_o(ex_valid),
        .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd),
        .ex_regwr_o(ex_regwr), .ex_memwr_o(ex_memwr),
        .ex_memrd_o(ex_memrd), .ex_alusrc_o(ex_alusrc),
        .ex_aluop_o(ex_aluop), .ex_imm_o(ex_imm), .ex_rdat1_o(ex_rdat1),
        .ex_rdat2_o(ex_rdat2), .ex_npc_o(ex_npc), .bubble_cnt_o(bcnt)
    );

    function automatic logic model_hazard();
        logic reads;
        reads = (uses_rs && id_rs == m_rd) || (uses_rt && id_rt == m_rd);
        return m_valid && m_memrd && m_rd != 0 && id_valid && reads;
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        m_regwr = 0; m_memwr = 0; m_memrd = 0; m_alusrc = 0;
        m_aluop = ALU_SLL;
        m_imm = 0; m_rdat1 = 0; m_rdat2 = 0; m_npc = 0;
    endtask

    task automatic model_reset();
        model_bubble();
        m_cnt = 0;
        m_pend = 0;
    endtask

    task automatic model_step();
        logic [4:0] dst;
        logic h;
        h = model_hazard();
        case (regdst)
            2'd0: dst = id_rt;
            2'd1: dst = id_rd;
            2'd2: dst = 5'd31;
            default: dst = 5'd0;
        endcase
        if (!en) begin
            if (flush) m_pend = 1;
        end else if (flush || m_pend) begin
            model_bubble();
            m_pend = 0;
        end else if (h) begin
            model_bubble();
            if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1;
        end else begin
            m_valid = id_valid;
            m_rs = id_rs; m_rt = id_rt; m_rd = dst;
            m_regwr = regwr && dst != 0;
            m_memwr = memwr; m_memrd = memrd; m_alusrc = alusrc;
            m_aluop = aluop; m_imm = imm; m_npc = npc;
            m_rdat1 = (wb_regwr && wb_rd == id_rs && id_rs != 0)
                      ? wb_wdat : rdat1;
            m_rdat2 = (wb_regwr && wb_rd == id_rt && id_rt != 0)
                      ? wb_wdat : rdat2;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 0;
        #2;
        model_reset();
        nRST = 1;
        #1;
    endtask

    task automatic set_idle();
        en = 1; flush = 0; id_valid = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; uses_rs = 0; uses_rt = 0;
        regdst = 0; regwr = 0; memwr = 0; memrd = 0; alusrc = 0;
        aluop = ALU_SLL; imm = 0; rdat1 = 0; rdat2 = 0; npc = 0;
        wb_regwr = 0; wb_rd = 0; wb_wdat = 0;
    endtask

    task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic urs,
                             input logic urt, input logic [1:0] dst,
                             input logic wr, input logic mr);
        id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd;
        uses_rs = urs; uses_rt = urt; regdst = dst;
        regwr = wr; memrd = mr; memwr = 0;
        alusrc = 1'($urandom); aluop = ALU_ADD;
        imm = $urandom; rdat1 = $urandom; rdat2 = $urandom;
        npc = $urandom;
        wb_regwr = 0;
    endtask

    task automatic test_reset();
        en = 1; flush = 1; id_valid = 1;
        id_rs = 8; id_rt = 8; id_rd = 8; uses_rs = 1; uses_rt = 1;
        regdst = 1; regwr = 1; memwr = 1; memrd = 1; alusrc = 1;
        aluop = ALU_SUB; imm = 32'h11; rdat1 = 32'h22; rdat2 = 32'h33;
        npc = 32'h44; wb_regwr = 1; wb_rd = 8; wb_wdat = 32'h55;
        nRST = 0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        tests++;
        if ({ex_valid, ex_rs, ex_rt, ex_rd, ex_regwr, ex_memwr, ex_memrd,
             ex_alusrc, ex_aluop, ex_imm, ex_rdat1, ex_rdat2, ex_npc,
             bcnt} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b rd=%0d imm=%h cnt=%0d required all 0",
                     ex_valid, ex_rd, ex_imm, bcnt);
        end
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_stall: got %b required 0", stall);
        end
        nRST = 1;
        set_idle();
        set_instr(1, 2, 3, 1, 1, 1, 1, 0);
        tick();
        #2;
        nRST = 0;
        #1;
        tests++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin
            fails++;
            $display("FAIL async_reset: got valid=%b rd=%0d required 0/0",
                     ex_valid, ex_rd);
        end
        model_reset();
        nRST = 1;
        #1;
    endtask

    task automatic test_load_use();
        logic [CNT_W-1:0] c0;
        set_idle();
        set_instr(2, 8, 0, 1, 0, 0, 1, 1);
        tick();
        set_instr(8, 3, 10, 1, 1, 1, 1, 0);
        #1;
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL load_use_stall: got %b required 1", stall);
        end
        c0 = m_cnt;
        tick();
        tests++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || bcnt !== c0 + 1'b1) begin
            fails++;
            $display("FAIL load_use_bubble: got valid=%b rd=%0d cnt=%0d required 0/0/%0d",
                     ex_valid, ex_rd, bcnt, c0 + 1'b1);
        end
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL load_use_clear: got stall %b required 0", stall);
        end
        tick();
        tests++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd10) begin
            fails++;
            $display("FAIL load_use_add: got valid=%b rd=%0d required 1/10",
                     ex_valid, ex_rd);
        end
    endtask

    task automatic test_zero_reg();
        set_idle();
        set_instr(2, 0, 0, 1, 0, 0, 1, 1);
        tick();
        tests++;
        if (ex_regwr !== 1'b0) begin
            fails++;
            $display("FAIL zero_regwr: got %b required 0", ex_regwr);
        end
        set_instr(0, 4, 10, 1, 0, 1, 1, 0);
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL zero_stall: got %b required 0", stall);
        end
        tick();
        tests++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd10) begin
            fails++;
            $display("FAIL zero_add: got valid=%b rd=%0d required 1/10",
                     ex_valid, ex_rd);
        end
    endtask

    task automatic test_bypass();
        set_idle();
        set_instr(4, 9, 11, 1, 1, 1, 1, 0);
        rdat1 = 32'h55; rdat2 = 32'h1;
        wb_regwr = 1; wb_rd = 9; wb_wdat = 32'hDEADBEEF;
        tick();
        tests++;
        if (ex_rdat2 !== 32'hDEADBEEF || ex_rdat1 !== 32'h55) begin
            fails++;
            $display("FAIL bypass_rt: got rdat1=%h rdat2=%h required 00000055/deadbeef",
                     ex_rdat1, ex_rdat2);
        end
        set_instr(0, 5, 11, 1, 1, 1, 1, 0);
        rdat1 = 32'h77; rdat2 = 32'h66;
        wb_regwr = 1; wb_rd = 0; wb_wdat = 32'hCAFEF00D;
        tick();
        tests++;
        if (ex_rdat1 !== 32'h77 || ex_rdat2 !== 32'h66) begin
            fails++;
            $display("FAIL bypass_r0: got rdat1=%h rdat2=%h required 00000077/00000066",
                     ex_rdat1, ex_rdat2);
        end
    endtask

    task automatic test_jal();
        set_idle();
        set_instr(0, 6, 5, 0, 0, 2, 1, 0);
        tick();
        tests++;
        if (ex_rd !== 5'd31 || ex_regwr !== 1'b1) begin
            fails++;
            $display("FAIL jal_link: got rd=%0d regwr=%b required 31/1",
                     ex_rd, ex_regwr);
        end
        set_instr(0, 6, 5, 0, 0, 3, 1, 0);
        tick();
        tests++;
        if (ex_rd !== 5'd0 || ex_regwr !== 1'b0) begin
            fails++;
            $display("FAIL regdst3: got rd=%0d regwr=%b required 0/0",
                     ex_rd, ex_regwr);
        end
    endtask

    task automatic test_deferred_flush();
        set_idle();
        set_instr(1, 2, 3, 1, 1, 1, 1, 0);
        imm = 32'h1234; npc = 32'h400;
        tick();
        en = 0; flush = 1;
        set_instr(4, 5, 7, 1, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            flush = 0;
            tests++;
            if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_imm !== 32'h1234
                || ex_npc !== 32'h400) begin
                fails++;
                $display("FAIL hold_%0d: got valid=%b rd=%0d imm=%h npc=%h required 1/3/1234/400",
                         i, ex_valid, ex_rd, ex_imm, ex_npc);
            end
        end
        en = 1;
        tick();
        tests++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd0) begin
            fails++;
            $display("FAIL deferred_bubble: got valid=%b rd=%0d required 0/0",
                     ex_valid, ex_rd);
        end
        tick();
        tests++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd7) begin
            fails++;
            $display("FAIL after_flush: got valid=%b rd=%0d required 1/7",
                     ex_valid, ex_rd);
        end
    endtask

    task automatic test_flush_vs_hazard();
        logic [CNT_W-1:0] c0;
        set_idle();
        set_instr(2, 8, 0, 1, 0, 0, 1, 1);
        tick();
        set_instr(8, 3, 10, 1, 1, 1, 1, 0);
        flush = 1;
        #1;
        tests++;
        if (stall !== 1'b1) begin
            fails++;
            $display("FAIL fvh_stall: got %b required 1", stall);
        end
        c0 = m_cnt;
        tick();
        tests++;
        if (ex_valid !== 1'b0 || bcnt !== c0) begin
            fails++;
            $display("FAIL fvh_bubble: got valid=%b cnt=%0d required 0/%0d",
                     ex_valid, bcnt, c0);
        end
        flush = 0;
        tick();
        tests++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd10) begin
            fails++;
            $display("FAIL fvh_next: got valid=%b rd=%0d required 1/10",
                     ex_valid, ex_rd);
        end
    endtask

    task automatic test_reset_mid_hold();
        set_idle();
        en = 0; flush = 1;
        tick();
        do_reset();
        set_idle();
        set_instr(1, 2, 12, 1, 1, 1, 1, 0);
        tick();
        tests++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd12) begin
            fails++;
            $display("FAIL reset_drops_pend: got valid=%b rd=%0d required 1/12",
                     ex_valid, ex_rd);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_idle();
        for (int i = 0; i < 9; i++) begin
            set_instr(2, 8, 0, 1, 0, 0, 1, 1);
            tick();
            set_instr(8, 3, 10, 1, 1, 1, 1, 0);
            tick();
            tick();
        end
        tests++;
        if (bcnt !== {CNT_W{1'b1}}) begin
            fails++;
            $display("FAIL saturation: got cnt=%0d required %0d",
                     bcnt, {CNT_W{1'b1}});
        end
    endtask

    task automatic test_random();
        logic [154:0] got, exp;
        do_reset();
        set_idle();
        for (int i = 0; i < 400; i++) begin
            en = ($urandom % 8) != 0;
            flush = ($urandom % 10) == 0;
            id_valid = ($urandom % 4) != 0;
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 3));
            uses_rs = 1'($urandom); uses_rt = 1'($urandom);
            regdst = 2'($urandom);
            regwr = 1'($urandom); memwr = 1'($urandom);
            memrd = 1'($urandom); alusrc = 1'($urandom);
            aluop = aluop_t'($urandom_range(0, 10));
            imm = $urandom; rdat1 = $urandom; rdat2 = $urandom;
            npc = $urandom;
            wb_regwr = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 3));
            wb_wdat = $urandom;
            #1;
            tests++;
            if (stall !== model_hazard()) begin
                fails++;
                $display("FAIL rand_stall[%0d]: got %b required %b",
                         i, stall, model_hazard());
            end
            tick();
            got = {ex_valid, ex_rs, ex_rt, ex_rd, ex_regwr, ex_memwr,
                   ex_memrd, ex_alusrc, ex_aluop, ex_imm, ex_rdat1,
                   ex_rdat2, ex_npc, bcnt};
            exp = {m_valid, m_rs, m_rt, m_rd, m_regwr, m_memwr,
                   m_memrd, m_alusrc, m_aluop, m_imm, m_rdat1,
                   m_rdat2, m_npc, m_cnt};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL rand_ex[%0d]: got %h required %h",
                         i, got, exp);
            end
        end
    endtask

    initial begin
        set_idle();
        nRST = 0;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_bypass();
        test_jal();
        test_deferred_flush();
        test_flush_vs_hazard();
        test_reset_mid_hold();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
